kbd_rx_ctrl: RTL and testbench
==============================

// Module: kbd_rx_ctrl
// PURPOSE
//  Sequencer and buffer between the ps2_kbd receiver and the CPU MMIO keyboard port.
//  Polls kbd_ready and pops each scancode with a one-cycle active-low kbd_rdn strobe.
//  Stores scancodes in a local FIFO and serves CPU pop requests with a fixed 1-cycle latency.
//  Counts bytes lost on FIFO overflow.
//  All logic is in the clk200m domain; ps2_kbd is clocked from the same clk200m.
// PARAMETERS
//  DEPTH_LOG2  4  FIFO depth = 2**DEPTH_LOG2 entries of 8 bits
//  SETTLE_CYC  2  idle cycles after each kbd_rdn strobe before kbd_ready is sampled again (>=1)
// PORTS
//  clk200m       in   1             system clock, rising edge
//  rst           in   1             reset, asynchronous, active-high
//  kbd_data      in   8             scancode from ps2_kbd, valid while kbd_ready=1
//  kbd_ready     in   1             ps2_kbd holds at least one byte
//  kbd_overflow  in   1             ps2_kbd internal overflow; status only, passed through
//  kbd_rdn       out  1             active-low pop strobe to ps2_kbd
//  cpu_rd        in   1             CPU pop request, one cycle per byte
//  cpu_rdata     out  8             popped byte
//  cpu_rvalid    out  1             cpu_rdata valid; high for exactly 1 cycle
//  fifo_empty    out  1             FIFO holds 0 entries
//  fifo_full     out  1             FIFO holds 2**DEPTH_LOG2 entries
//  fifo_count    out  DEPTH_LOG2+1  number of entries held
//  drop_cnt      out  8             saturating count of dropped bytes
//  drop_clr      in   1             synchronous clear of drop_cnt
//  hw_overflow   out  1             registered copy of kbd_overflow
// BEHAVIOUR
//  Reset values (async):
//   - kbd_rdn=1; cpu_rdata=0; cpu_rvalid=0; fifo_empty=1; fifo_full=0.
//   - fifo_count=0; drop_cnt=0; hw_overflow=0.
//   - Read/write pointers=0; FSM=IDLE.
//  FSM: IDLE -> ACK -> SETTLE -> IDLE.
//   - IDLE: kbd_rdn=1. If kbd_ready=1, latch kbd_data and go to ACK.
//   - ACK: kbd_rdn=0 for exactly 1 cycle. The latched byte is offered to the FIFO write port in this cycle.
//   - SETTLE: kbd_rdn=1. Count SETTLE_CYC cycles, then return to IDLE. kbd_ready is ignored while in SETTLE.
//  Push rules:
//   - Push in ACK when not full.
//   - If full in ACK, the byte is dropped and drop_cnt increments, saturating at 255.
//   - The ps2 byte is popped from ps2_kbd either way.
//  Pop rules:
//   - cpu_rd=1 with FIFO non-empty: head byte is driven on cpu_rdata with cpu_rvalid=1 in the next cycle; read pointer advances.
//   - cpu_rd=1 with FIFO empty: next cycle cpu_rvalid=0 and cpu_rdata=0; no state change.
//   - cpu_rdata holds its last value while cpu_rvalid=0, except after an empty pop, which drives 0.
//  Simultaneous push and pop in one cycle:
//   - Both happen; fifo_count is unchanged.
//   - When full, the simultaneous pop frees the slot, so the push is accepted and nothing is dropped.
//   - When empty, the pop still returns empty; the pushed byte is available from the next cycle.
//  Pointers: DEPTH_LOG2 bits, wrap modulo depth. fifo_count is computed from a separate up/down counter, never from pointer difference alone.
//  drop_clr: has priority over a same-cycle drop increment; drop_cnt=0 in the next cycle.
//  hw_overflow: kbd_overflow registered once (1-cycle delay); not sticky.
//  Reset mid-operation: kbd_rdn returns to 1 immediately (async); the FIFO is emptied; a byte in flight is lost and not counted.
// CONFIGURATION
//  KBD_BREAK_FILTER_EN:
//   - Defined: a byte 0xF0 is not pushed and arms a skip flag. The next byte from ps2_kbd is also not pushed, and the flag clears.
//   - Defined: 0xE0 is pushed normally. Filtered bytes never count as drops. The skip flag resets to 0.
//   - Undefined: every byte is pushed. There is no skip-flag logic.
// TESTING
//  1. Send 0x1C with kbd_ready: kbd_rdn low exactly 1 cycle. Next kbd_ready sample no earlier than ACK+SETTLE_CYC+1. fifo_count=1.
//  2. Push 16 bytes 0x01..0x10, then cpu_rd x16: read back 0x01..0x10 in order, each with cpu_rvalid 1 cycle after cpu_rd. Afterwards fifo_empty=1.
//  3. Fill the FIFO, then send 3 more bytes: drop_cnt=3 and the FIFO contents are unchanged. Pulse drop_clr: drop_cnt=0.
//  4. Full FIFO, ACK and cpu_rd in the same cycle: drop_cnt stays 0 and fifo_count stays 16. The new byte is returned last.
//  5. cpu_rd while empty: cpu_rvalid=0 and cpu_rdata=0 next cycle. Assert rst during ACK: kbd_rdn=1 immediately and fifo_count=0.
//  6. Send 0x1C,0xF0,0x1C,0xE0: with KBD_BREAK_FILTER_EN the FIFO holds 1C,E0. Without it the FIFO holds all 4 bytes.

Source files
------------

// File: rtl/kbd_rx_ctrl.sv
// Keyboard receive sequencer: pops scancodes from ps2_kbd and buffers them for CPU MMIO reads.
// Optional build macro KBD_BREAK_FILTER_EN drops 0xF0 break prefixes and the byte that follows each one.
module kbd_rx_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk200m,
    input  logic                  rst,
    input  logic [7:0]            kbd_data,
    input  logic                  kbd_ready,
    input  logic                  kbd_overflow,
    output logic                  kbd_rdn,
    input  logic                  cpu_rd,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_rvalid,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic [7:0]            drop_cnt,
    input  logic                  drop_clr,
    output logic                  hw_overflow,
    output logic [1:0]            dbg_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [7:0]           byte_q;
    logic [7:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]  count_q;
    logic                 accept;
    logic                 push_req, do_push, do_pop, drop;

    // Handshake: the latched byte is offered to the FIFO only during ACK;
    // a pop is taken when cpu_rd is high and the FIFO holds at least one entry.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                settle_d = '0;
                if (kbd_ready) state_d = ST_ACK;
            end
            ST_ACK: begin
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = ST_IDLE;
                else settle_d = settle_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            byte_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            if (state_q == ST_IDLE && kbd_ready) byte_q <= kbd_data;
        end
    end

    // Decoded straight from the state register so reset releases the strobe immediately.
    assign kbd_rdn   = (state_q != ST_ACK);
    assign dbg_state = state_q;

`ifdef KBD_BREAK_FILTER_EN
    logic skip_q;

    always_comb begin
        accept = 1'b1;
        if (skip_q || byte_q == 8'hF0) accept = 1'b0;
    end

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) skip_q <= 1'b0;
        else if (state_q == ST_ACK) skip_q <= !skip_q && (byte_q == 8'hF0);
    end
`else
    assign accept = 1'b1;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign fifo_count = count_q;

    assign push_req = (state_q == ST_ACK) && accept;
    assign do_pop   = cpu_rd && !fifo_empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign do_push  = push_req && (!fifo_full || do_pop);
    assign drop     = push_req && fifo_full && !do_pop;

    always_ff @(posedge clk200m) begin
        if (do_push) mem[wr_ptr] <= byte_q;
    end

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            cpu_rvalid <= do_pop;
            if (do_pop)      cpu_rdata <= mem[rd_ptr];
            else if (cpu_rd) cpu_rdata <= '0;
        end
    end

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            drop_cnt    <= '0;
            hw_overflow <= 1'b0;
        end else begin
            hw_overflow <= kbd_overflow;
            if (drop_clr) drop_cnt <= '0;
            else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// Directed bench for kbd_rx_ctrl with a small ps2_kbd stand-in that queues bytes and pops on kbd_rdn.
`timescale 1ns/1ps
module tb_kbd_rx_ctrl;
    localparam int DL = 4;

    logic          clk200m = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    kbd_data = 8'h00;
    logic          kbd_ready = 1'b0;
    logic          kbd_overflow = 1'b0;
    logic          kbd_rdn;
    logic          cpu_rd = 1'b0;
    logic [7:0]    cpu_rdata;
    logic          cpu_rvalid;
    logic          fifo_empty;
    logic          fifo_full;
    logic [DL:0]   fifo_count;
    logic [7:0]    drop_cnt;
    logic          drop_clr = 1'b0;
    logic          hw_overflow;
    logic [1:0]    dbg_state;

    int npass = 0;
    int ntot  = 0;
    logic [7:0] kq[$];

    kbd_rx_ctrl #(.DEPTH_LOG2(DL), .SETTLE_CYC(2)) dut (
        .clk200m(clk200m), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_rdn(kbd_rdn), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .drop_cnt(drop_cnt),
        .drop_clr(drop_clr), .hw_overflow(hw_overflow), .dbg_state(dbg_state)
    );

    // clock / reset
    always #2.5 clk200m = ~clk200m;

    // ps2_kbd stand-in: pops on the edge that ends the active-low strobe
    always @(posedge clk200m) begin
        if (!kbd_rdn && kq.size() != 0) void'(kq.pop_front());
    end
    always @(negedge clk200m) begin
        kbd_ready = (kq.size() != 0);
        kbd_data  = (kq.size() != 0) ? kq[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk200m);
        #1;
    endtask

    task automatic wait_drain();
        int left = 200;
        while (kq.size() != 0 && left > 0) begin
            tick();
            left--;
        end
        if (left == 0) chk("drain_timeout", 1, 0);
        repeat (4) tick();
    endtask

    task automatic cpu_pop(input string tag, input logic exp_v, input logic [7:0] exp_d);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        chk({tag, "_rvalid"}, 32'(cpu_rvalid), 32'(exp_v));
        chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp_d));
    endtask

    task automatic wait_ack();
        int left = 40;
        while (kbd_rdn && left > 0) begin
            tick();
            left--;
        end
        if (left == 0) chk("ack_timeout", 1, 0);
    endtask

    initial begin
        int lows[$];
        repeat (3) tick();
        // reset state
        chk("rst_kbd_rdn", 32'(kbd_rdn), 1);
        chk("rst_rdata", 32'(cpu_rdata), 0);
        chk("rst_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_hwovf", 32'(hw_overflow), 0);
        rst = 1'b0;
        tick();

        // hw_overflow is a one-cycle delayed, non-sticky copy
        kbd_overflow = 1'b1;
        chk("hwovf_delay", 32'(hw_overflow), 0);
        tick();
        chk("hwovf_set", 32'(hw_overflow), 1);
        kbd_overflow = 1'b0;
        tick();
        chk("hwovf_clr", 32'(hw_overflow), 0);

        // single strobe width and ACK-to-ACK spacing of SETTLE_CYC+2
        kq.push_back(8'h1C);
        kq.push_back(8'h2D);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!kbd_rdn) lows.push_back(i);
        end
        chk("strobe_count", 32'(lows.size()), 2);
        if (lows.size() == 2) chk("strobe_gap", 32'(lows[1] - lows[0]), 4);
        chk("t1_count", 32'(fifo_count), 2);
        cpu_pop("t1_pop0", 1'b1, 8'h1C);
        cpu_pop("t1_pop1", 1'b1, 8'h2D);
        chk("t1_empty", 32'(fifo_empty), 1);

        // fill 16 then drain in order
        for (int i = 1; i <= 16; i++) kq.push_back(8'(i));
        wait_drain();
        chk("t2_count", 32'(fifo_count), 16);
        chk("t2_full", 32'(fifo_full), 1);
        for (int i = 1; i <= 16; i++) cpu_pop("t2_pop", 1'b1, 8'(i));
        chk("t2_empty", 32'(fifo_empty), 1);
        chk("t2_count0", 32'(fifo_count), 0);

        // overflow: 19 bytes into 16 slots
        for (int i = 0; i < 19; i++) kq.push_back(8'(8'h20 + i));
        wait_drain();
        chk("t3_drop", 32'(drop_cnt), 3);
        chk("t3_count", 32'(fifo_count), 16);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        chk("t3_dropclr", 32'(drop_cnt), 0);

        // full FIFO: ACK and cpu_rd in the same cycle
        kq.push_back(8'h77);
        wait_ack();
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        chk("t4_rvalid", 32'(cpu_rvalid), 1);
        chk("t4_rdata", 32'(cpu_rdata), 32'h20);
        chk("t4_count", 32'(fifo_count), 16);
        repeat (3) tick();
        chk("t4_drop", 32'(drop_cnt), 0);
        for (int i = 1; i < 16; i++) cpu_pop("t4_pop", 1'b1, 8'(8'h20 + i));
        cpu_pop("t4_last", 1'b1, 8'h77);

        // pop while empty
        cpu_pop("t5_emptypop", 1'b0, 8'h00);
        chk("t5_count", 32'(fifo_count), 0);

        // reset during ACK
        kq.push_back(8'h44);
        wait_drain();
        chk("t5_pre_count", 32'(fifo_count), 1);
        kq.push_back(8'h55);
        wait_ack();
        rst = 1'b1;
        #0.5;
        chk("t5_rst_rdn", 32'(kbd_rdn), 1);
        chk("t5_rst_count", 32'(fifo_count), 0);
        kq.delete();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("t5_post_count", 32'(fifo_count), 0);
        chk("t5_post_drop", 32'(drop_cnt), 0);

        // break-prefix filter
        kq.push_back(8'h1C);
        kq.push_back(8'hF0);
        kq.push_back(8'h1C);
        kq.push_back(8'hE0);
        wait_drain();
`ifdef KBD_BREAK_FILTER_EN
        chk("t6_count", 32'(fifo_count), 2);
        cpu_pop("t6_pop0", 1'b1, 8'h1C);
        cpu_pop("t6_pop1", 1'b1, 8'hE0);
`else
        chk("t6_count", 32'(fifo_count), 4);
        cpu_pop("t6_pop0", 1'b1, 8'h1C);
        cpu_pop("t6_pop1", 1'b1, 8'hF0);
        cpu_pop("t6_pop2", 1'b1, 8'h1C);
        cpu_pop("t6_pop3", 1'b1, 8'hE0);
`endif
        chk("t6_drop", 32'(drop_cnt), 0);
        chk("t6_empty", 32'(fifo_empty), 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
